// File: rtl/alu_input_pkg.sv
// Shared constants for the ALU input sequencer: state codes and default widths.
// Optional debounce is selected by ALU_SEQ_DEBOUNCE_EN (see button_conditioner).
package alu_input_pkg;

    localparam int STATE_W      = 2;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_OP_WIDTH = 6;

    typedef enum logic [STATE_W-1:0] {
        S_LOAD_A  = 2'b00,
        S_LOAD_B  = 2'b01,
        S_LOAD_OP = 2'b10,
        S_SHOW    = 2'b11
    } state_e;

endpackage

// File: rtl/alu_input_sequencer_button_conditioner.sv
// Pushbutton front end: 2-flop synchroniser, optional debouncer, rising-edge detector.
// Define ALU_SEQ_DEBOUNCE_EN to include the debounce counter; otherwise the synchronised level is used directly.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    logic [1:0] sync_q, sync_d;
    logic       level_prev_q, level_prev_d;
    logic       level;

    if (DEBOUNCE_CYCLES < 2) begin : g_cycles_below_min
    end

`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;

    // Counter only advances while the synchronised input disagrees with the accepted level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
`else
    assign level = sync_q[1];
`endif

    always_comb begin
        sync_d       = {sync_q[0], btn_raw};
        level_prev_d = level;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q       <= '0;
            level_prev_q <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            level_prev_q <= level_prev_d;
        end
    end

    assign press = level & ~level_prev_q;

endmodule

// File: rtl/alu_input_sequencer.sv
// Sequences switch values into the A, B and opcode registers, one button press per step.
// Button debouncing is enabled by defining ALU_SEQ_DEBOUNCE_EN.
module alu_input_sequencer
    import alu_input_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int OP_WIDTH        = DEF_OP_WIDTH,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn,
    input  logic [WIDTH-1:0]   sw,
    output logic [WIDTH-1:0]   data_out,
    output logic               load_a,
    output logic               load_b,
    output logic               load_op,
    output logic [STATE_W-1:0] state_out,
    output logic               result_valid
);

    logic press;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             load_a_q, load_a_d;
    logic             load_b_q, load_b_d;
    logic             load_op_q, load_op_d;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn),
        .press  (press)
    );

    // Load pulses and captured data are registered together so they reach the datapath aligned.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        load_a_d  = 1'b0;
        load_b_d  = 1'b0;
        load_op_d = 1'b0;
        if (press) begin
            unique case (state_q)
                S_LOAD_A: begin
                    state_d  = S_LOAD_B;
                    data_d   = sw;
                    load_a_d = 1'b1;
                end
                S_LOAD_B: begin
                    state_d  = S_LOAD_OP;
                    data_d   = sw;
                    load_b_d = 1'b1;
                end
                S_LOAD_OP: begin
                    state_d   = S_SHOW;
                    data_d    = WIDTH'(sw[OP_WIDTH-1:0]);
                    load_op_d = 1'b1;
                end
                S_SHOW: begin
                    state_d = S_LOAD_A;
                end
                default: begin
                    state_d = S_LOAD_A;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_LOAD_A;
            data_q    <= '0;
            load_a_q  <= 1'b0;
            load_b_q  <= 1'b0;
            load_op_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            load_a_q  <= load_a_d;
            load_b_q  <= load_b_d;
            load_op_q <= load_op_d;
        end
    end

    assign data_out     = data_q;
    assign load_a       = load_a_q;
    assign load_b       = load_b_q;
    assign load_op      = load_op_q;
    assign state_out    = state_q;
    assign result_valid = (state_q == S_SHOW);

endmodule
